uart_rx_os: RTL and testbench
=============================

# uart_rx_os

Oversampling UART receiver that consumes the single-cycle baud tick from the baud-rate generator (mod-M counter, 16× baud) and the raw serial line. It recovers asynchronous frames of start, DBIT data bits (LSB first), optional parity and stop. Each frame is presented through a one-entry holding register with a valid/ready handshake. It sits between the baud generator and the receive FIFO/consumer logic.

## Interface
- DBIT, 8: data bits per frame, 5..8
- SB_TICK, 16: oversample ticks in the stop phase; 16 = 1 stop bit, 24 = 1.5, 32 = 2
- PARITY_EN, 0: 1 = one parity bit follows the data
- PARITY_ODD, 0: 1 = odd parity, 0 = even; ignored when PARITY_EN=0

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- s_tick  in  1  one-clk pulse at 16× baud, from baud generator
- rx  in  1  raw serial input, asynchronous, idle high
- rx_data  out  DBIT  received data word
- rx_valid  out  1  holding register contains an unconsumed frame
- rx_ready  in  1  consumer accepts the frame when rx_valid && rx_ready
- frame_err  out  1  stop sample was 0 for the held frame
- parity_err  out  1  parity mismatch for the held frame; always 0 when PARITY_EN=0
- overrun  out  1  sticky: a completed frame was dropped because the holding register was full
- busy  out  1  FSM not in IDLE

## Operation
- rx passes through a 2-flop synchronizer; both flops reset to 1. The FSM uses only the synchronized value rxs.
- Counters:
  - s (4 bits) counts s_tick within a bit.
  - n (3 bits) counts data bits.
  - b (DBIT bits) is the shift register.
  - s, n and b change only on s_tick, except when IDLE clears them on start detect.
- IDLE: rxs==0 → START, s=0.
- START: on tick with s==7, mid-bit check:
  - rxs==0 → DATA, s=0, n=0.
  - rxs==1 → IDLE (glitch rejected, nothing reported).
  - Otherwise s++.
- DATA: on tick with s==15:
  - s=0, b={rxs, b[DBIT-1:1]}.
  - If n==DBIT-1 → PARITY (PARITY_EN=1) or STOP; else n++.
  - Otherwise s++.
- PARITY: on tick with s==15:
  - s=0.
  - Latch perr = (^b ^ rxs ^ PARITY_ODD) != 0.
  - → STOP.
- STOP: on tick with s==SB_TICK-1 (s widened as needed for SB_TICK up to 32):
  - Sample rxs; ferr = ~rxs.
  - Assert internal done for one clk; → IDLE.
  - Otherwise s++.
- On done:
  - If !rx_valid, or rx_valid && rx_ready in the same clk: load rx_data=b, frame_err=ferr, parity_err=perr, rx_valid=1.
  - Else: drop the frame, holding register unchanged, overrun=1.
- Handshake (rx_valid && rx_ready, no simultaneous load): rx_valid=0 and overrun=0. rx_data and the error flags hold their last values.
- Frames with frame_err or parity_err are still delivered. The error flags qualify rx_data.
- When DBIT<8, b is right-aligned: the first received bit is in rx_data[0].

## Timing
- Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, FSM IDLE, synchronizer =1.
- Reset is honoured mid-frame: partial frame discarded, holding register cleared.
- Start detect: busy rises 3 clk after rx falls (2 synchronizer + 1 FSM).
- Frame latency: rx_valid rises 1 clk after the s_tick that completes the stop phase.
- Bit sampling happens 8 ticks after the detected falling edge, then every 16 ticks.
- s_tick pulses are assumed ≥2 clk apart. Without ticks the FSM holds state indefinitely.
- rx_ready is ignored when rx_valid=0.
- Simultaneous done and handshake: new frame is loaded, rx_valid stays 1, overrun unchanged (cleared by the handshake).
- A falling edge of rxs during STOP is ignored until IDLE. Back-to-back frames are accepted with zero idle ticks after the stop sample.

## Test plan
- 8N1 baseline (s_tick every 4 clk): send 0xA5 → rx_data=0xA5, rx_valid=1, frame_err=0, parity_err=0; rx_valid holds until rx_ready=1, then drops the next clk.
- Glitch: rx low for 5 ticks, then high → FSM returns to IDLE, busy falls, rx_valid never asserts.
- Framing error: 0x3C with stop bit driven 0 → rx_data=0x3C, rx_valid=1, frame_err=1.
- Parity, PARITY_EN=1, PARITY_ODD=0:
  - 0x07 with parity bit 0 → parity_err=1.
  - 0x07 with parity bit 1 → parity_err=0.
- Overrun, rx_ready=0: send 0x11 then 0x22 → rx_data=0x11, overrun=1. Pulse rx_ready → rx_valid=0, overrun=0.
- Handshake on done: assert rx_ready on the clk 0x22 completes → rx_data=0x22, rx_valid=1, overrun=0.
- Reset mid-DATA: assert reset after 3 data bits → all outputs 0; the following frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 16x tick sampling, DBIT data bits LSB first, optional parity,
// one-entry holding register with valid/ready handshake and sticky overrun.
module uart_rx_os #(
   parameter int unsigned DBIT       = 8,
   parameter int unsigned SB_TICK    = 16,
   parameter int unsigned PARITY_EN  = 0,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_tick,
   input  logic            rx,
   output logic [DBIT-1:0] rx_data,
   output logic            rx_valid,
   input  logic            rx_ready,
   output logic            frame_err,
   output logic            parity_err,
   output logic            overrun,
   output logic            busy
);

   // Tick counter must reach SB_TICK-1 in the stop phase (up to 31 for two stop bits).
   localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam logic        ODD = (PARITY_ODD != 0);
   localparam logic        PEN = (PARITY_EN != 0);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;

   state_t            state;
   logic [SW-1:0]     s;
   logic [2:0]        n;
   logic [DBIT-1:0]   b;
   logic              perr;
   logic              rx_meta;
   logic              rxs;
   logic              done;
   logic              ferr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   assign done = (state == StStop) && s_tick && (s == SW'(SB_TICK - 1));
   assign ferr = ~rxs;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= StIdle;
         s     <= '0;
         n     <= '0;
         b     <= '0;
         perr  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (!rxs) begin
                  state <= StStart;
                  s     <= '0;
                  n     <= '0;
                  b     <= '0;
                  busy  <= 1'b1;
               end
            end
            StStart: begin
               if (s_tick) begin
                  if (s == SW'(7)) begin
                     s <= '0;
                     n <= '0;
                     if (!rxs) begin
                        state <= StData;
                     end else begin
                        // Start bit gone by mid-bit: treat as a glitch.
                        state <= StIdle;
                        busy  <= 1'b0;
                     end
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            StData: begin
               if (s_tick) begin
                  if (s == SW'(15)) begin
                     s <= '0;
                     b <= {rxs, b[DBIT-1:1]};
                     if (n == 3'(DBIT - 1)) begin
                        state <= PEN ? StParity : StStop;
                     end else begin
                        n <= n + 1'b1;
                     end
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            StParity: begin
               if (s_tick) begin
                  if (s == SW'(15)) begin
                     s     <= '0;
                     perr  <= (^b) ^ rxs ^ ODD;
                     state <= StStop;
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            StStop: begin
               if (s_tick) begin
                  if (s == SW'(SB_TICK - 1)) begin
                     s     <= '0;
                     state <= StIdle;
                     busy  <= 1'b0;
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Holding register: a frame completing while one is still held is dropped unless the
   // held one is being consumed in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else if (done) begin
         if (!rx_valid || rx_ready) begin
            rx_data    <= b;
            frame_err  <= ferr;
            parity_err <= perr;
            rx_valid   <= 1'b1;
            if (rx_valid) begin
               overrun <= 1'b0;
            end
         end else begin
            overrun <= 1'b1;
         end
      end else if (rx_valid && rx_ready) begin
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: an 8N1 instance and an 8E1 instance share clock, reset, tick.
module tb_uart_rx_os;

   logic       clk = 1'b0;
   logic       reset;
   logic       s_tick;
   logic       rx, rxp;
   logic       rdy, rdyp;
   logic [7:0] data, datap;
   logic       valid, validp, ferr, ferrp, perr, perrp, ovr, ovrp, busy, busyp;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   uart_rx_os #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
      .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx), .rx_data(data), .rx_valid(valid),
      .rx_ready(rdy), .frame_err(ferr), .parity_err(perr), .overrun(ovr), .busy(busy)
   );

   uart_rx_os #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dutp (
      .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rxp), .rx_data(datap), .rx_valid(validp),
      .rx_ready(rdyp), .frame_err(ferrp), .parity_err(perrp), .overrun(ovrp), .busy(busyp)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One s_tick every 4 clk; optionally pulse rx_ready (8N1 instance) on the tick clk.
   task automatic tick(input bit rdy_pulse);
      @(negedge clk);
      s_tick = 1'b1;
      if (rdy_pulse) rdy = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
      rdy    = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic ticks(input int cnt);
      for (int i = 0; i < cnt; i++) tick(1'b0);
   endtask

   task automatic set_line(input bit sel, input bit v);
      if (sel) rxp = v;
      else rx = v;
   endtask

   // Full frame, 16 ticks per bit; the stop sample lands on stop tick index 8.
   task automatic send(input bit sel, input logic [7:0] d, input bit par_en, input bit par_bit,
                       input bit stop_bit, input bit rdy_done);
      set_line(sel, 1'b0);
      ticks(16);
      for (int i = 0; i < 8; i++) begin
         set_line(sel, d[i]);
         ticks(16);
      end
      if (par_en) begin
         set_line(sel, par_bit);
         ticks(16);
      end
      set_line(sel, stop_bit);
      for (int k = 0; k < 16; k++) tick(rdy_done && (k == 8));
      set_line(sel, 1'b1);
   endtask

   task automatic consume(input bit sel);
      @(negedge clk);
      if (sel) rdyp = 1'b1;
      else rdy = 1'b1;
      @(negedge clk);
      rdyp = 1'b0;
      rdy  = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      s_tick = 1'b0;
      rx     = 1'b1;
      rxp    = 1'b1;
      rdy    = 1'b0;
      rdyp   = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_data", data, 0);
      check("reset_valid", valid, 0);
      check("reset_ferr", ferr, 0);
      check("reset_perr", perr, 0);
      check("reset_ovr", ovr, 0);
      check("reset_busy", busy, 0);
      reset = 1'b0;
      ticks(4);

      // 8N1 baseline
      send(0, 8'hA5, 0, 0, 1, 0);
      check("a5_data", data, 8'hA5);
      check("a5_valid", valid, 1);
      check("a5_ferr", ferr, 0);
      check("a5_perr", perr, 0);
      check("a5_busy", busy, 0);
      repeat (5) @(negedge clk);
      check("a5_hold", valid, 1);
      consume(0);
      check("a5_drop", valid, 0);
      check("a5_data_kept", data, 8'hA5);

      // Glitch: 5 ticks low, then high
      rx = 1'b0;
      ticks(2);
      check("glitch_busy_rise", busy, 1);
      ticks(3);
      rx = 1'b1;
      ticks(11);
      check("glitch_busy_fall", busy, 0);
      check("glitch_valid", valid, 0);

      // Framing error
      send(0, 8'h3C, 0, 0, 0, 0);
      check("ferr_data", data, 8'h3C);
      check("ferr_valid", valid, 1);
      check("ferr_flag", ferr, 1);
      consume(0);
      ticks(16);

      // Overrun: two back-to-back frames, no consumer
      send(0, 8'h11, 0, 0, 1, 0);
      check("ovr_first_ovr", ovr, 0);
      send(0, 8'h22, 0, 0, 1, 0);
      check("ovr_data", data, 8'h11);
      check("ovr_valid", valid, 1);
      check("ovr_flag", ovr, 1);
      check("ovr_ferr", ferr, 0);
      consume(0);
      check("ovr_clr_valid", valid, 0);
      check("ovr_clr_flag", ovr, 0);

      // Handshake in the same clk as done
      send(0, 8'h33, 0, 0, 1, 0);
      check("hs_first", data, 8'h33);
      send(0, 8'h22, 0, 0, 1, 1);
      check("hs_data", data, 8'h22);
      check("hs_valid", valid, 1);
      check("hs_ovr", ovr, 0);

      // Even parity, 0x07 has three ones
      send(1, 8'h07, 1, 0, 1, 0);
      check("par0_data", datap, 8'h07);
      check("par0_valid", validp, 1);
      check("par0_perr", perrp, 1);
      check("par0_ferr", ferrp, 0);
      consume(1);
      send(1, 8'h07, 1, 1, 1, 0);
      check("par1_valid", validp, 1);
      check("par1_perr", perrp, 0);

      // Reset mid-DATA with a held frame on the 8N1 instance
      check("rst_pre_valid", valid, 1);
      rx = 1'b0;
      ticks(16);
      for (int i = 0; i < 3; i++) begin
         rx = i[0];
         ticks(16);
      end
      check("rst_pre_busy", busy, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_data", data, 0);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ovr", ovr, 0);
      check("rst_p_data", datap, 0);
      check("rst_p_perr", perrp, 0);
      rx    = 1'b1;
      reset = 1'b0;
      ticks(16);
      send(0, 8'h5A, 0, 0, 1, 0);
      check("post_rst_data", data, 8'h5A);
      check("post_rst_valid", valid, 1);
      check("post_rst_ferr", ferr, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
